// File: rtl/shift_add_mult_4bit.sv
// shift_add_mult_4bit: 4x4 unsigned sequential shift-and-add multiplier.
// One 4-bit ripple-carry adder is reused for all four partial-product steps.
// After an operand pair is accepted, four CALC cycles follow, then a single
// DONE cycle that pulses done with P valid.
// Optional feature macro: MULT_ZERO_SKIP_EN. When it is defined, a zero
// operand jumps straight to DONE with P = 0 and busy never rises.

module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] carry;

    // Bit-serial ripple of the carry through four full adders
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

module shift_add_mult_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] P
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] mplr_q,  mplr_d;
    logic [7:0] acc_q,   acc_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [7:0] p_q,     p_d;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       cout;

    // Partial product for this step: the multiplicand when the current
    // multiplier LSB is set, otherwise zero
    always_comb begin
        addend = mplr_q[0] ? mcand_q : 4'h0;
    end

    RCA_4bit u_rca (
        .a    (acc_q[7:4]),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = A;
                    mplr_d  = B;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MULT_ZERO_SKIP_EN
                    if ((A == 4'h0) || (B == 4'h0)) begin
                        state_d = DONE;
                        p_d     = '0;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                // Carry out of the adder lands in acc[7]; the shift drops acc[0]
                acc_d  = {cout, sum, acc_q[3:1]};
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                    p_d     = {cout, sum, acc_q[3:1]};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Status outputs decode directly from the registered state
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
        P    = p_q;
    end

endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// Testbench for shift_add_mult_4bit: directed vector table, hand-written
// corner sequences, exhaustive sweep, and randomized traffic checked every
// cycle against a transaction-level reference model.
// Honours MULT_ZERO_SKIP_EN when it is defined for the build.

module tb_shift_add_mult_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    shift_add_mult_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: an operation is a product computed with plain
    // arithmetic, delivered after a fixed number of cycles
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_p    = 8'h00;
    logic [7:0] m_prod = 8'h00;
    bit         mon_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_p    <= 8'h00;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_p    <= m_prod;
            end
        end else if (start) begin
            m_prod <= 8'(int'(A) * int'(B));
            if (SKIP && (A == 4'h0 || B == 4'h0)) begin
                m_done <= 1'b1;
                m_p    <= 8'h00;
            end else begin
                m_left <= 4;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check8("mon_busy", {7'b0, busy}, {7'b0, (m_left > 0)});
            check8("mon_done", {7'b0, done}, {7'b0, m_done});
            check8("mon_P", P, m_p);
            if (busy === 1'b1 && done === 1'b1) check8("mon_busy_and_done", 8'h01, 8'h00);
        end
    end

    // One full transaction from IDLE; checks latency, product and hold
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input string name);
        int c;
        int lat;
        lat   = (SKIP && (a == 4'h0 || b == 4'h0)) ? 1 : 5;
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = 4'($urandom);
        B     = 4'($urandom);
        c     = 1;
        while (done !== 1'b1 && c < 12) begin
            @(negedge clk);
            c++;
        end
        check_int({name, "_latency"}, c, lat);
        check8({name, "_P"}, P, exp_p);
        @(negedge clk);
        check8({name, "_hold"}, P, exp_p);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[8];
    int   done_cyc[$];

    initial begin
        vecs[0] = '{4'd3,  4'd5,  8'h0F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd0,  4'd9,  8'h00};
        vecs[3] = '{4'd2,  4'd3,  8'h06};
        vecs[4] = '{4'd1,  4'd1,  8'h01};
        vecs[5] = '{4'd15, 4'd1,  8'h0F};
        vecs[6] = '{4'd8,  4'd0,  8'h00};
        vecs[7] = '{4'd12, 4'd10, 8'h78};

        rst_n = 1'b0;
        start = 1'b1;
        A     = 4'd7;
        B     = 4'd7;
        @(negedge clk);
        @(negedge clk);
        check8("reset_busy", {7'b0, busy}, 8'h00);
        check8("reset_done", {7'b0, done}, 8'h00);
        check8("reset_P", P, 8'h00);
        start = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, "table");

        // busy high for exactly the four CALC cycles of 3*5
        start = 1'b1; A = 4'd3; B = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check8("busy_window", {7'b0, busy}, {7'b0, (c <= 4)});
            if (c < 5) @(negedge clk);
        end
        check8("busy_window_P", P, 8'h0F);
        @(negedge clk);

        // start held through CALC with new operands: single result, then
        // second request only after returning to IDLE
        start = 1'b1; A = 4'd6; B = 4'd7;
        @(negedge clk);
        A = 4'd2; B = 4'd2;
        for (int c = 2; c <= 5; c++) @(negedge clk);
        check8("held_done", {7'b0, done}, 8'h01);
        check8("held_P", P, 8'h2A);
        @(negedge clk);
        check8("held_idle_busy", {7'b0, busy}, 8'h00);
        check8("held_idle_done", {7'b0, done}, 8'h00);
        @(negedge clk);
        check8("held_second_busy", {7'b0, busy}, 8'h01);
        start = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        check8("held_second_done", {7'b0, done}, 8'h01);
        check8("held_second_P", P, 8'h04);
        @(negedge clk);

        // Reset mid-calculation aborts without a done pulse
        start = 1'b1; A = 4'd9; B = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check8("abort_busy", {7'b0, busy}, 8'h00);
        check8("abort_done", {7'b0, done}, 8'h00);
        check8("abort_P", P, 8'h00);
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check8("abort_no_done", {7'b0, done}, 8'h00);
        end
        run_op(4'd2, 4'd3, 8'h06, "after_abort");

        // Back-to-back with start held high: one result every 6 cycles
        start = 1'b1; A = 4'd4; B = 4'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc.push_back(c);
                check8("b2b_P", P, 8'h10);
            end
        end
        start = 1'b0;
        check_int("b2b_count", done_cyc.size(), 3);
        for (int i = 1; i < done_cyc.size(); i++)
            check_int("b2b_period", done_cyc[i] - done_cyc[i-1], 6);
        for (int c = 0; c < 7; c++) @(negedge clk);

        // Exhaustive sweep against plain multiplication
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), 8'(a * b), "sweep");

        // Randomized traffic, including sporadic resets, judged by the model
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 2) == 0);
            A     = 4'($urandom);
            B     = 4'($urandom);
            rst_n = ($urandom_range(0, 39) != 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) @(negedge clk);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
